// File: rtl/flag_cond_unit.sv
// Flag register and outstanding-op tracker for the ALU compare path.
// Answers branch-unit condition queries once all flag writes older than the query have landed.
module flag_cond_unit #(
  parameter int MAX_PENDING = 3,
  localparam int CNT_W = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  output logic             issue_ready_o,
  input  logic             flags_we_i,
  input  logic [3:0]       flags_i,
  output logic [3:0]       flags_o,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       cond_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             taken_o,
  output logic             err_o,
  output logic [1:0]       dbg_state_o,
  output logic [CNT_W-1:0] dbg_pending_o
);

  // Handshakes: a query transfers on a rising edge where req_valid_i && req_ready_o;
  // a response is offered with resp_valid_o, taken_o held stable, until resp_ready_i is seen high.

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PENDING);

  state_t           state, state_next;
  logic [3:0]       flags_q, flags_next;
  logic [CNT_W-1:0] pending, pending_next;
  logic [CNT_W-1:0] wait_cnt, wait_next;
  logic [3:0]       cond_q, cond_next;
  logic             taken_q, taken_next;
  logic             err_q, err_set;
  logic             full, issue_acc, write_ret;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic v, n, z, cf, r;
    v  = f[3];
    n  = f[2];
    z  = f[1];
    cf = f[0];
    r  = 1'b0;
    case (c)
      4'h0: r = z;
      4'h1: r = !z;
      4'h2: r = cf;
      4'h3: r = !cf;
      4'h4: r = !cf && !z;
      4'h5: r = cf || z;
      4'h6: r = n ^ v;
      4'h7: r = !(n ^ v);
      4'h8: r = !z && !(n ^ v);
      4'h9: r = z || (n ^ v);
      4'hA: r = n;
      4'hB: r = !n;
      4'hC: r = v;
      4'hD: r = !v;
      4'hE: r = 1'b1;
      4'hF: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // A write with nothing in flight retires nothing; an issue into a full tracker is dropped.
  always_comb begin
    flags_next   = flags_we_i ? flags_i : flags_q;
    full         = (pending == MAXP);
    issue_acc    = issue_i && (!full || flags_we_i);
    write_ret    = flags_we_i && ((pending != '0) || issue_i);
    err_set      = (flags_we_i && (pending == '0) && !issue_i) ||
                   (issue_i && full && !flags_we_i);
    pending_next = pending;
    if (issue_acc && !write_ret)
      pending_next = pending + ONE;
    else if (!issue_acc && write_ret)
      pending_next = pending - ONE;
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    cond_next  = cond_q;
    taken_next = taken_q;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          cond_next = cond_i;
          // Same-cycle issue counts as older than the query.
          if (pending_next == '0) begin
            taken_next = eval_cond(cond_i, flags_next);
            state_next = RESP;
          end else begin
            wait_next  = pending_next;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (flags_we_i) begin
          if (wait_cnt == ONE) begin
            taken_next = eval_cond(cond_q, flags_next);
            state_next = RESP;
          end else begin
            wait_next = wait_cnt - ONE;
          end
        end
      end
      RESP: begin
        if (resp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      flags_q  <= '0;
      pending  <= '0;
      wait_cnt <= '0;
      cond_q   <= '0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      flags_q  <= flags_next;
      pending  <= pending_next;
      wait_cnt <= wait_next;
      cond_q   <= cond_next;
      taken_q  <= taken_next;
      err_q    <= err_q || err_set;
    end
  end

  assign flags_o       = flags_q;
  assign issue_ready_o = !full;
  assign req_ready_o   = (state == IDLE);
  assign resp_valid_o  = (state == RESP);
  assign taken_o       = taken_q;
  assign err_o         = err_q;
  assign dbg_state_o   = state;
  assign dbg_pending_o = pending;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: directed scenarios then random traffic, checked against
// an op-counting reference model through an expected-response queue.
module tb_flag_cond_unit;

  localparam int MAXP  = 3;
  localparam int CNT_W = $clog2(MAXP + 1);

  logic             clk_i = 1'b0;
  logic             rst_i, issue_i, flags_we_i, req_valid_i, resp_ready_i;
  logic [3:0]       flags_i, cond_i;
  logic             issue_ready_o, req_ready_o, resp_valid_o, taken_o, err_o;
  logic [3:0]       flags_o;
  logic [1:0]       dbg_state_o;
  logic [CNT_W-1:0] dbg_pending_o;

  flag_cond_unit #(.MAX_PENDING(MAXP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .issue_i(issue_i), .issue_ready_o(issue_ready_o),
    .flags_we_i(flags_we_i), .flags_i(flags_i), .flags_o(flags_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .cond_i(cond_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .taken_o(taken_o),
    .err_o(err_o), .dbg_state_o(dbg_state_o), .dbg_pending_o(dbg_pending_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  // Ops are counted, not staged: a query waits until the number of retired ops
  // reaches the number of ops issued up to and including its accept cycle.
  logic [0:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         started  = 0;
  logic [3:0] m_flags;
  int         m_pend, m_issued, m_retired, m_target;
  bit         m_err, m_acc;
  int         m_q;           // 0 no query, 1 awaiting older ops, 2 response offered
  logic [3:0] m_cond;

  function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
    bit v, n, z, cy;
    v = f[3]; n = f[2]; z = f[1]; cy = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return !cy && !z;
      4'h5: return cy || z;
      4'h6: return n != v;
      4'h7: return n == v;
      4'h8: return !z && (n == v);
      4'h9: return z || (n != v);
      4'hA: return n;
      4'hB: return !n;
      4'hC: return v;
      4'hD: return !v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] fn;
    bit iss_ok, ret;
    started = 1;
    m_acc   = 0;
    if (rst_i) begin
      m_flags = '0; m_pend = 0; m_issued = 0; m_retired = 0; m_target = 0;
      m_err = 0; m_q = 0; m_cond = '0;
      exp_q.delete();
      return;
    end
    fn     = flags_we_i ? flags_i : m_flags;
    iss_ok = issue_i && (m_pend < MAXP || flags_we_i);
    ret    = flags_we_i && (m_pend > 0 || issue_i);
    if ((flags_we_i && m_pend == 0 && !issue_i) || (issue_i && m_pend == MAXP && !flags_we_i))
      m_err = 1;
    m_issued  += int'(iss_ok);
    m_retired += int'(ret);
    m_pend     = m_issued - m_retired;
    case (m_q)
      0: if (req_valid_i) begin
        m_acc = 1; m_cond = cond_i; m_target = m_issued;
        m_q = 1;
      end
      2: if (resp_ready_i) m_q = 0;
      default: ;
    endcase
    if (m_q == 1 && m_retired >= m_target) begin
      exp_q.push_back(ref_eval(m_cond, fn));
      m_q = 2;
    end
    m_flags = fn;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic rst, input logic iss, input logic we, input logic [3:0] fl,
                     input logic rv, input logic [3:0] cd, input logic rr);
    rst_i = rst; issue_i = iss; flags_we_i = we; flags_i = fl;
    req_valid_i = rv; cond_i = cd; resp_ready_i = rr;
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'h0, 0, 4'h0, 1);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 4'h0, 0, 4'h0, 0);
    cyc(1, 0, 0, 4'h0, 0, 4'h0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    if (started) begin
      chk("flags_o", 32'(flags_o), 32'(m_flags));
      chk("pending", 32'(dbg_pending_o), 32'(m_pend));
      chk("issue_ready_o", 32'(issue_ready_o), 32'(m_pend < MAXP));
      chk("err_o", 32'(err_o), 32'(m_err));
      chk("req_ready_o", 32'(req_ready_o), 32'(m_q == 0));
      chk("resp_valid_o", 32'(resp_valid_o), 32'(m_q == 2));
      if (resp_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL resp_unexpected: got response taken=%0b expected none (t=%0t)", taken_o, $time);
        end else begin
          chk("taken_o", 32'(taken_o), 32'(exp_q[0]));
          if (resp_ready_i === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       r_rv;
    logic [3:0] r_cond;
    bit         iss, we, rr, rst;

    do_reset();
    chk("reset_flags", 32'(flags_o), 32'h0);
    chk("reset_resp_valid", 32'(resp_valid_o), 32'h0);

    // Same-cycle issue + write + query: EQ on ZF set, answered next cycle.
    cyc(0, 1, 1, 4'b0010, 1, 4'h0, 1);
    chk("t1_resp_valid", 32'(resp_valid_o), 32'h1);
    chk("t1_taken", 32'(taken_o), 32'h1);
    idle(2);

    // Two older ops; writes at t3 and t5, response at t6.
    do_reset();
    cyc(0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 0, 0, 4'h0, 1, 4'h2, 0);      // t0
    idle(2);
    cyc(0, 0, 1, 4'b0000, 0, 4'h0, 0);   // t3
    chk("t2_wait_after_first", 32'(resp_valid_o), 32'h0);
    idle(1);
    cyc(0, 0, 1, 4'b0001, 0, 4'h0, 1);   // t5
    chk("t2_resp_valid", 32'(resp_valid_o), 32'h1);
    chk("t2_taken", 32'(taken_o), 32'h1);
    idle(2);

    // Younger issue during WAIT is not awaited.
    do_reset();
    cyc(0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 0, 0, 4'h0, 1, 4'h3, 0);
    cyc(0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 0, 1, 4'b0000, 0, 4'h0, 0);
    chk("t3_resp_valid", 32'(resp_valid_o), 32'h1);
    chk("t3_taken", 32'(taken_o), 32'h1);
    chk("t3_pending", 32'(dbg_pending_o), 32'h1);
    idle(2);

    // Overflow: fourth issue dropped and flagged.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'h0, 0, 4'h0, 0);
    chk("t4_issue_ready", 32'(issue_ready_o), 32'h0);
    chk("t4_err_before", 32'(err_o), 32'h0);
    cyc(0, 1, 0, 4'h0, 0, 4'h0, 0);
    chk("t4_err", 32'(err_o), 32'h1);
    chk("t4_pending", 32'(dbg_pending_o), 32'h3);

    // Underflow write, then a response held under back-pressure.
    do_reset();
    cyc(0, 0, 1, 4'b1010, 0, 4'h0, 0);
    chk("t5_err", 32'(err_o), 32'h1);
    chk("t5_flags", 32'(flags_o), 32'hA);
    cyc(0, 0, 0, 4'h0, 1, 4'h6, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4'(i), 0, 4'h0, 0);
    chk("t5_held_taken", 32'(taken_o), 32'h1);
    cyc(0, 0, 0, 4'h0, 0, 4'h0, 1);
    chk("t5_released", 32'(resp_valid_o), 32'h0);

    // Reset while waiting drops the query.
    do_reset();
    cyc(0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 0, 1, 4'h5, 1, 4'h0, 0);
    cyc(0, 1, 0, 4'h0, 0, 4'h0, 0);
    cyc(0, 0, 0, 4'h0, 1, 4'h1, 0);
    cyc(1, 0, 0, 4'h0, 0, 4'h0, 0);
    chk("t6_req_ready", 32'(req_ready_o), 32'h1);
    chk("t6_resp_valid", 32'(resp_valid_o), 32'h0);
    chk("t6_flags", 32'(flags_o), 32'h0);

    // Random traffic; query valid is held with a stable code until accepted.
    do_reset();
    r_rv = 0; r_cond = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      iss = (m_pend < MAXP) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 49) == 0);
      we  = (m_pend > 0) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) == 0);
      rr  = ($urandom_range(0, 99) < 60);
      if (!r_rv && $urandom_range(0, 99) < 30) begin
        r_rv = 1; r_cond = 4'($urandom);
      end
      cyc(rst, iss, we, 4'($urandom), r_rv, r_cond, rr);
      if (m_acc || rst) r_rv = 0;
    end

    // Drain outstanding ops and any open query.
    for (int i = 0; i < 20 && (m_pend > 0 || m_q != 0); i++)
      cyc(0, 0, m_pend > 0, 4'($urandom), 0, 4'h0, 1);
    idle(1);
    chk("drain_exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
